// File: rtl/sha1_pkg.sv
// sha1_pkg
// Shared definitions for the SHA-1 compression engine:
//   - round constants K0..K3, one per group of 20 rounds
//   - the standard SHA-1 initial chaining value IV (H0 in the top word)
//   - controller state encoding
//   - fixed-distance left-rotate helpers used by the round and the schedule
package sha1_pkg;

  localparam logic [31:0]  K0 = 32'h5A827999;
  localparam logic [31:0]  K1 = 32'h6ED9EBA1;
  localparam logic [31:0]  K2 = 32'h8F1BBCDC;
  localparam logic [31:0]  K3 = 32'hCA62C1D6;

  localparam logic [159:0] IV = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    FINAL
  } state_t;

  function automatic logic [31:0] rotl1(input logic [31:0] x);
    return {x[30:0], x[31]};
  endfunction

  function automatic logic [31:0] rotl5(input logic [31:0] x);
    return {x[26:0], x[31:27]};
  endfunction

  function automatic logic [31:0] rotl30(input logic [31:0] x);
    return {x[1:0], x[31:2]};
  endfunction

endpackage

// File: rtl/sha1_round.sv
// sha1_round
// One purely combinational SHA-1 round.
// Ports:
//   i_a..i_e  : current working variables A..E
//   i_w       : message schedule word W_t for this round
//   i_t       : round index 0..79, selects the boolean function and constant
//   o_a..o_e  : working variables after this round
module sha1_round
  import sha1_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [31:0] i_c,
  input  logic [31:0] i_d,
  input  logic [31:0] i_e,
  input  logic [31:0] i_w,
  input  logic [6:0]  i_t,
  output logic [31:0] o_a,
  output logic [31:0] o_b,
  output logic [31:0] o_c,
  output logic [31:0] o_d,
  output logic [31:0] o_e
);

  logic [31:0] w_f;
  logic [31:0] w_k;

  // The 80 rounds fall into four groups of 20. Groups 1 and 3 share the
  // parity function but use different constants, so f and K are picked
  // independently from the round index. Parity is the default so that
  // both outputs are always assigned.
  always_comb begin
    w_f = i_b ^ i_c ^ i_d;
    w_k = K1;
    if (i_t < 7'd20) begin
      w_f = (i_b & i_c) | (~i_b & i_d);
      w_k = K0;
    end else if (i_t < 7'd40) begin
      w_f = i_b ^ i_c ^ i_d;
      w_k = K1;
    end else if (i_t < 7'd60) begin
      w_f = (i_b & i_c) | (i_b & i_d) | (i_c & i_d);
      w_k = K2;
    end else begin
      w_f = i_b ^ i_c ^ i_d;
      w_k = K3;
    end
  end

  // Only A gets new content; the other variables shift down, with B
  // rotated by 30 on its way into C. All additions wrap mod 2^32.
  assign o_a = rotl5(i_a) + w_f + i_e + w_k + i_w;
  assign o_b = i_a;
  assign o_c = rotl30(i_b);
  assign o_d = i_c;
  assign o_e = i_d;

endmodule

// File: rtl/sha1_core.sv
// sha1_core
// SHA-1 compression engine: takes one pre-padded 512-bit block and a
// 160-bit chaining value and produces H_in + compress(H_in, block), one
// round per clock (81 cycles from accepting start to the result).
// Ports:
//   clk         : system clock, rising edge
//   rstn        : synchronous active-low reset
//   start       : begin a block; only looked at while idle
//   use_prev_cv : at start, take the chaining value from cv_next instead of cv
//   data_i      : message block, W0 in bits [511:480] down to W15 in [31:0]
//   cv          : external chaining value, H0 in bits [159:128] .. H4 in [31:0]
//   busy        : high while a block is in flight
//   out_valid   : one-cycle pulse when cv_next has just been updated
//   cv_next     : result chaining value, held until the next completion
module sha1_core
  import sha1_pkg::*;
#(
  parameter int ROUNDS = 80
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  input  logic         use_prev_cv,
  input  logic [511:0] data_i,
  input  logic [159:0] cv,
  output logic         busy,
  output logic         out_valid,
  output logic [159:0] cv_next
);

  state_t       r_state;
  logic [31:0]  r_w [16];
  logic [159:0] r_h;
  logic [31:0]  r_a;
  logic [31:0]  r_b;
  logic [31:0]  r_c;
  logic [31:0]  r_d;
  logic [31:0]  r_e;
  logic [6:0]   r_t;
  logic         r_busy;
  logic         r_out_valid;
  logic [159:0] r_cv_next;

  logic [3:0]   w_idx;
  logic [3:0]   w_idx3;
  logic [3:0]   w_idx8;
  logic [3:0]   w_idx14;
  logic [31:0]  w_sched;
  logic [31:0]  w_wt;
  logic [159:0] w_h_in;
  logic [31:0]  w_a_nx;
  logic [31:0]  w_b_nx;
  logic [31:0]  w_c_nx;
  logic [31:0]  w_d_nx;
  logic [31:0]  w_e_nx;

  // The schedule lives in a 16-entry ring indexed by t mod 16. Slot t mod 16
  // still holds W[t-16] when round t runs, so the expanded word can be
  // written straight back over it. Offsets -3/-8/-14 become +13/+8/+2 in
  // 4-bit wrap-around arithmetic.
  assign w_idx   = r_t[3:0];
  assign w_idx3  = w_idx + 4'd13;
  assign w_idx8  = w_idx + 4'd8;
  assign w_idx14 = w_idx + 4'd2;
  assign w_sched = rotl1(r_w[w_idx3] ^ r_w[w_idx8] ^ r_w[w_idx14] ^ r_w[w_idx]);
  assign w_wt    = (r_t < 7'd16) ? r_w[w_idx] : w_sched;

  // Feeding back our own previous result lets a driver chain multi-block
  // messages without reading the digest out between blocks.
  assign w_h_in  = use_prev_cv ? r_cv_next : cv;

  sha1_round u_round (
    .i_a (r_a),
    .i_b (r_b),
    .i_c (r_c),
    .i_d (r_d),
    .i_e (r_e),
    .i_w (w_wt),
    .i_t (r_t),
    .o_a (w_a_nx),
    .o_b (w_b_nx),
    .o_c (w_c_nx),
    .o_d (w_d_nx),
    .o_e (w_e_nx)
  );

  // Controller and datapath registers together. IDLE accepts a block and
  // snapshots every input it needs, so the driver may change data_i/cv
  // right away. ROUND steps one round per clock; FINAL adds the working
  // variables back onto the saved input chaining value and pulses
  // out_valid. start is simply not looked at outside IDLE, which is what
  // makes a held-high start harmless during a run. Returning to IDLE after
  // FINAL lets a start present on the very next edge begin a new block.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_cv_next   <= '0;
      r_h         <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_c         <= '0;
      r_d         <= '0;
      r_e         <= '0;
      r_t         <= '0;
      for (int i = 0; i < 16; i++) begin
        r_w[i] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          r_out_valid <= 1'b0;
          if (start) begin
            for (int i = 0; i < 16; i++) begin
              r_w[i] <= data_i[511-32*i -: 32];
            end
            r_h     <= w_h_in;
            r_a     <= w_h_in[159:128];
            r_b     <= w_h_in[127:96];
            r_c     <= w_h_in[95:64];
            r_d     <= w_h_in[63:32];
            r_e     <= w_h_in[31:0];
            r_t     <= '0;
            r_busy  <= 1'b1;
            r_state <= ROUND;
          end
        end
        ROUND: begin
          r_a <= w_a_nx;
          r_b <= w_b_nx;
          r_c <= w_c_nx;
          r_d <= w_d_nx;
          r_e <= w_e_nx;
          if (r_t >= 7'd16) begin
            r_w[w_idx] <= w_sched;
          end
          if (r_t == 7'(ROUNDS - 1)) begin
            r_state <= FINAL;
          end else begin
            r_t <= r_t + 7'd1;
          end
        end
        FINAL: begin
          r_cv_next   <= {r_h[159:128] + r_a,
                          r_h[127:96]  + r_b,
                          r_h[95:64]   + r_c,
                          r_h[63:32]   + r_d,
                          r_h[31:0]    + r_e};
          r_out_valid <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign cv_next   = r_cv_next;

endmodule

// File: tb/tb_sha1_core.sv
// tb_sha1_core
// Self-checking bench for sha1_core. Known SHA-1 digests cover the standard
// vectors; a straightforward software model of the compression function
// (full 80-word schedule array) covers randomized blocks and chaining values.
module tb_sha1_core;

  localparam logic [159:0] TB_IV      = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;
  localparam logic [159:0] ABC_DIGEST = 160'ha9993e364706816aba3e25717850c26c9cd0d89d;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         start = 1'b0;
  logic         use_prev_cv = 1'b0;
  logic [511:0] data_i = '0;
  logic [159:0] cv = '0;
  logic         busy;
  logic         out_valid;
  logic [159:0] cv_next;

  int           compared = 0;
  int           mismatched = 0;
  logic [159:0] expCvNext = '0;

  logic [511:0] abcBlk;
  logic [511:0] emptyBlk;
  logic [511:0] twoBlk1;
  logic [511:0] twoBlk2;

  sha1_core dut (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
    .use_prev_cv (use_prev_cv),
    .data_i      (data_i),
    .cv          (cv),
    .busy        (busy),
    .out_valid   (out_valid),
    .cv_next     (cv_next)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Plain software SHA-1 compression: expand all 80 words up front, then
  // run the rounds and add the result onto the incoming chaining value.
  function automatic logic [159:0] sha1Model(input logic [159:0] h, input logic [511:0] blk);
    logic [31:0] w [80];
    logic [31:0] a, b, c, d, e, f, k, tmp;
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 80; t++) w[t] = rol(w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16], 1);
    a = h[159:128]; b = h[127:96]; c = h[95:64]; d = h[63:32]; e = h[31:0];
    for (int t = 0; t < 80; t++) begin
      if (t < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
      else if (t < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
      else if (t < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
      else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
      tmp = rol(a, 5) + f + e + k + w[t];
      e = d; d = c; c = rol(b, 30); b = a; a = tmp;
    end
    return {h[159:128] + a, h[127:96] + b, h[95:64] + c, h[63:32] + d, h[31:0] + e};
  endfunction

  function automatic logic [511:0] randBlock();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [159:0] randCv();
    logic [159:0] r;
    for (int i = 0; i < 5; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Runs one block from the current cycle: start is presented for one edge,
  // inputs are then scrambled to prove they were captured, and the
  // completion is awaited with a bounded loop. Returns at #1 after the
  // out_valid edge so a following call starts back-to-back.
  task automatic applyStimulus(input string tag, input logic [511:0] blk, input logic [159:0] cvIn,
                               input logic usePrev, input logic [159:0] expDigest);
    int   cycles;
    logic seen;
    start       = 1'b1;
    data_i      = blk;
    cv          = cvIn;
    use_prev_cv = usePrev;
    @(posedge clk); #1;
    start       = 1'b0;
    data_i      = randBlock();
    cv          = randCv();
    use_prev_cv = ~usePrev;
    checkOutput({tag, " busyHigh"}, 160'(busy), 160'(1));
    seen   = 1'b0;
    cycles = 0;
    while (!seen && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
      if (out_valid) seen = 1'b1;
    end
    checkOutput({tag, " done"}, 160'(seen), 160'(1));
    checkOutput({tag, " latency"}, 160'(cycles), 160'(81));
    checkOutput({tag, " busyLow"}, 160'(busy), 160'(0));
    checkOutput({tag, " digest"}, cv_next, expDigest);
    expCvNext = expDigest;
  endtask

  initial begin
    logic [511:0] blk;
    logic [159:0] c;
    logic         up;
    logic [159:0] got;
    int           pulses;
    int           doneCyc;

    abcBlk   = {"abc", 8'h80, 416'd0, 64'd24};
    emptyBlk = {8'h80, 504'd0};
    twoBlk1  = {"abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", 8'h80, 56'd0};
    twoBlk2  = {448'd0, 64'd448};

    // Reset state
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset busy", 160'(busy), 160'(0));
    checkOutput("reset outValid", 160'(out_valid), 160'(0));
    checkOutput("reset cvNext", cv_next, 160'(0));
    rstn = 1'b1;
    @(posedge clk); #1;

    // use_prev_cv straight after reset chains from an all-zero value
    blk = randBlock();
    applyStimulus("prevAfterReset", blk, randCv(), 1'b1, sha1Model(160'd0, blk));

    // Standard vectors
    applyStimulus("abc", abcBlk, TB_IV, 1'b0, ABC_DIGEST);
    applyStimulus("empty", emptyBlk, TB_IV, 1'b0, 160'hda39a3ee5e6b4b0d3255bfef95601890afd80709);

    // Two-block message, second block chained internally with cv driven to garbage
    applyStimulus("twoBlk1", twoBlk1, TB_IV, 1'b0, sha1Model(TB_IV, twoBlk1));
    applyStimulus("twoBlk2", twoBlk2, randCv(), 1'b1, 160'h84983e441c3bd26ebaae4aa1f95129e5e54670f1);

    // start held for 4 cycles with inputs changing mid-run: exactly one run
    start = 1'b1; data_i = abcBlk; cv = TB_IV; use_prev_cv = 1'b0;
    @(posedge clk); #1;
    data_i = randBlock(); cv = randCv(); use_prev_cv = 1'b1;
    pulses = 0; doneCyc = 0; got = '0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      if (cyc == 4) start = 1'b0;
      @(posedge clk); #1;
      if (out_valid) begin
        pulses++;
        if (pulses == 1) begin
          doneCyc = cyc;
          got = cv_next;
        end
      end
    end
    checkOutput("held pulses", 160'(pulses), 160'(1));
    checkOutput("held latency", 160'(doneCyc), 160'(81));
    checkOutput("held digest", got, ABC_DIGEST);
    expCvNext = ABC_DIGEST;

    // Reset asserted while round 40 would execute aborts the block
    start = 1'b1; data_i = randBlock(); cv = randCv(); use_prev_cv = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    checkOutput("midReset busy", 160'(busy), 160'(0));
    checkOutput("midReset outValid", 160'(out_valid), 160'(0));
    checkOutput("midReset cvNext", cv_next, 160'(0));
    rstn = 1'b1;
    expCvNext = '0;
    @(posedge clk); #1;
    applyStimulus("abcAfterReset", abcBlk, TB_IV, 1'b0, ABC_DIGEST);

    // Randomized blocks, back-to-back or with short idle gaps, random chaining
    for (int n = 0; n < 8; n++) begin
      blk = randBlock();
      c   = randCv();
      up  = 1'($urandom_range(0, 1));
      applyStimulus($sformatf("rand%0d", n), blk, c, up, sha1Model(up ? expCvNext : c, blk));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
        checkOutput($sformatf("rand%0d idleHold", n), cv_next, expCvNext);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sha1_core.md
Name: sha1_core

Overview:
- SHA-1 compression-function engine; processes one pre-padded 512-bit message block per start.
- Computes the 160-bit chaining value update, H_out = H_in + compress(H_in, block), at one round per clock.
- Padding and block sequencing are done by the surrounding logic (driver/CPU side).
- Supports multi-block messages by re-using its own previous result as the input chaining value.

Parameters:
- ROUNDS, 80, number of compression rounds (fixed by SHA-1; not meant to be overridden).

Ports:
- clk  input  1  system clock, rising edge
- rstn  input  1  reset, synchronous, active-low
- start  input  1  begin processing a block; sampled only when idle
- use_prev_cv  input  1  at start: 1 = initial CV is internal cv_next, 0 = use port cv
- data_i  input  512  message block; data_i[511:480] = W0 (first big-endian word) … data_i[31:0] = W15
- cv  input  160  external chaining value; cv[159:128] = H0 … cv[31:0] = H4
- busy  output  1  high while a block is being processed
- out_valid  output  1  one-cycle pulse when cv_next is updated
- cv_next  output  160  result chaining value, same word order as cv; held until the next completion

Behaviour:
- Reset (rstn=0 at rising clk): state←IDLE, busy←0, out_valid←0, cv_next←0, working regs←0. Reset mid-operation aborts the block, with no out_valid.
- States: IDLE, ROUND, FINAL.
- IDLE, start=1 at edge E:
  - latch W[0..15] from data_i;
  - latch H_in = use_prev_cv ? cv_next : cv;
  - A..E←H_in; round counter t←0; busy←1; state←ROUND.
- IDLE, start=0: nothing changes; out_valid←0.
- ROUND, edges E+1…E+80: one round per edge, t=0..79.
  - W_t = W[t] for t<16, else rotl1(W[t-3]^W[t-8]^W[t-14]^W[t-16]), kept in a 16-entry circular buffer indexed t mod 16.
  - f/K by t:
    - 0-19: (B&C)|(~B&D), K=5A827999;
    - 20-39: B^C^D, K=6ED9EBA1;
    - 40-59: (B&C)|(B&D)|(C&D), K=8F1BBCDC;
    - 60-79: B^C^D, K=CA62C1D6.
  - temp = rotl5(A)+f+E+K+W_t (mod 2^32); E←D; D←C; C←rotl30(B); B←A; A←temp.
  - After t=79, state←FINAL.
- FINAL, edge E+81:
  - cv_next ← {H0+A, H1+B, H2+C, H3+D, H4+E}, each 32-bit mod 2^32;
  - out_valid←1 for this one cycle; busy←0; state←IDLE.
- Latency: start sampled → busy falls with cv_next valid 81 cycles later; the block can be restarted on the very next edge.
- start while busy (ROUND/FINAL) is ignored; start held high across a whole run does not re-trigger during it. If start is still high in IDLE after completion, a new block begins.
- data_i, cv and use_prev_cv are sampled only at the accepting edge; later changes have no effect on the running block.
- use_prev_cv=1 after reset uses cv_next=0 (defined, not an error).
- cv_next is stable except at FINAL and at reset.

Decomposition:
- Package sha1_pkg:
  - round constants K0..K3;
  - IV constant 67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;
  - state enum {IDLE, ROUND, FINAL};
  - rotl helper functions.
- One combinational sub-module, sha1_round: inputs A..E, W_t, t; outputs next A..E.
- The schedule buffer, counter and FSM stay in sha1_core.

Test Plan:
- Block "abc", i.e. {"abc",8'h80,416'd0,64'd24}, with cv=IV, use_prev_cv=0 → after 81 cycles cv_next=a9993e364706816aba3e25717850c26c9cd0d89d, out_valid pulses once, busy low.
- Empty message, {8'h80,504'd0}, with cv=IV → cv_next=da39a3ee5e6b4b0d3255bfef95601890afd80709.
- Two-block chaining:
  - block 1 = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq",8'h80,56'd0 with cv=IV;
  - then block 2 = {448'd0,64'd448} with use_prev_cv=1 and cv port driven to garbage;
  - → cv_next=84983e441c3bd26ebaae4aa1f95129e5e54670f1.
- "abc" with start held high for 4 cycles then dropped, and data_i changed mid-run → single run, same "abc" digest, exactly one out_valid pulse.
- Assert rstn=0 at round 40 → busy=0, out_valid=0, cv_next=0 next edge; a subsequent "abc" run gives the correct digest.
- Back-to-back: start asserted on the edge right after out_valid → new run accepted immediately; busy high for that edge onward.
